// File: rtl/pc_sequencer_if.sv
// Control-decoder to PC-sequencer bus: operation select and targets in, PC/trace/stack status out.
interface pc_sequencer_if #(
  parameter int PC_W = 8
);
  logic            en;
  logic [2:0]      M;
  logic            cond;
  logic [PC_W-1:0] DATA_INPUT;
  logic [PC_W-1:0] res_alu;
  logic [PC_W-1:0] PC;
  logic [PC_W-1:0] Y;
  logic            sp_full;
  logic            sp_empty;
  logic            stk_err;

  modport master (
    output en, M, cond, DATA_INPUT, res_alu,
    input  PC, Y, sp_full, sp_empty, stk_err
  );

  modport slave (
    input  en, M, cond, DATA_INPUT, res_alu,
    output PC, Y, sp_full, sp_empty, stk_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with relative/conditional branches and a call/return stack.
// All state advances on the falling edge of clk; clr is a synchronous active-low reset.
module pc_sequencer #(
  parameter int              PC_W        = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
  input logic          clk,
  input logic          clr,
  pc_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_DEC  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_ALU  = 3'b011;
  localparam logic [2:0] OP_REL  = 3'b100;
  localparam logic [2:0] OP_CBR  = 3'b101;
  localparam logic [2:0] OP_CALL = 3'b110;
  localparam logic [2:0] OP_RET  = 3'b111;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             push_en;
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];

  logic [PC_W-1:0]  pc_inc;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;
  logic             full, empty;

  assign pc_inc   = pc_q + PC_W'(1);
  assign full     = (cnt_q == CNT_W'(STACK_DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_idx = IDX_W'(cnt_q);
  assign top_idx  = IDX_W'(cnt_q - CNT_W'(1));

  always_comb begin
    pc_d    = pc_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (bus.en) begin
      y_d = pc_q;
      unique case (bus.M)
        OP_INC:  pc_d = pc_inc;
        OP_DEC:  pc_d = pc_q - PC_W'(1);
        OP_LOAD: pc_d = bus.DATA_INPUT;
        OP_ALU:  pc_d = bus.res_alu;
        // Same-width add of the offset is exactly the sign-extended two's complement add
        OP_REL:  pc_d = pc_q + bus.DATA_INPUT;
        OP_CBR:  pc_d = bus.cond ? bus.DATA_INPUT : pc_inc;
        OP_CALL: begin
          if (full) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d    = bus.DATA_INPUT;
            cnt_d   = cnt_q + CNT_W'(1);
            push_en = 1'b1;
          end
        end
        OP_RET: begin
          if (empty) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d  = stack_q[top_idx];
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (!clr) begin
      pc_q  <= RESET_VEC;
      y_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry contents need no reset: the count alone decides what is live
  generate
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      always_ff @(negedge clk) begin
        if (clr && push_en && (push_idx == IDX_W'(gi))) begin
          stack_q[gi] <= pc_inc;
        end
      end
    end
  endgenerate

  assign bus.PC       = pc_q;
  assign bus.Y        = y_q;
  assign bus.sp_full  = full;
  assign bus.sp_empty = empty;
  assign bus.stk_err  = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: driver queues hand-computed expectations, monitor checks them.
module tb_pc_sequencer;
  logic clk;
  logic clr;

  pc_sequencer_if #(.PC_W(8)) bus ();

  pc_sequencer #(
    .PC_W       (8),
    .STACK_DEPTH(4),
    .RESET_VEC  (8'h00)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [7:0] y;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Inputs change on the rising edge; the DUT acts on the falling edge
  task automatic do_op(input logic c_clr, input logic e, input logic [2:0] m,
                       input logic cnd, input logic [7:0] d, input logic [7:0] alu,
                       input logic [7:0] e_pc, input logic [7:0] e_y,
                       input logic e_full, input logic e_empty, input logic e_err,
                       input string nm);
    exp_t x;
    @(posedge clk);
    clr            = c_clr;
    bus.en         = e;
    bus.M          = m;
    bus.cond       = cnd;
    bus.DATA_INPUT = d;
    bus.res_alu    = alu;
    @(negedge clk);
    x.name  = nm;
    x.pc    = e_pc;
    x.y     = e_y;
    x.full  = e_full;
    x.empty = e_empty;
    x.err   = e_err;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      total_cnt++;
      if (bus.PC === x.pc && bus.Y === x.y && bus.sp_full === x.full &&
          bus.sp_empty === x.empty && bus.stk_err === x.err) begin
        pass_cnt++;
        $display("ok   %-12s PC=%h Y=%h full=%b empty=%b err=%b",
                 x.name, bus.PC, bus.Y, bus.sp_full, bus.sp_empty, bus.stk_err);
      end else begin
        $display("FAIL %-12s got PC=%h Y=%h full=%b empty=%b err=%b, want PC=%h Y=%h full=%b empty=%b err=%b",
                 x.name, bus.PC, bus.Y, bus.sp_full, bus.sp_empty, bus.stk_err,
                 x.pc, x.y, x.full, x.empty, x.err);
      end
    end
  end

  initial begin
    clr            = 1'b0;
    bus.en         = 1'b0;
    bus.M          = 3'b000;
    bus.cond       = 1'b0;
    bus.DATA_INPUT = 8'h00;
    bus.res_alu    = 8'h00;

    //     clr  en  M       c  data   alu    PC     Y      F  E  Er
    do_op(1'b0, 1'b0, 3'b000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, "reset");
    do_op(1'b1, 1'b1, 3'b000, 0, 8'h00, 8'h00, 8'h01, 8'h00, 0, 1, 0, "inc1");
    do_op(1'b1, 1'b1, 3'b000, 0, 8'h00, 8'h00, 8'h02, 8'h01, 0, 1, 0, "inc2");
    do_op(1'b1, 1'b1, 3'b000, 0, 8'h00, 8'h00, 8'h03, 8'h02, 0, 1, 0, "inc3");
    do_op(1'b1, 1'b1, 3'b010, 0, 8'hFF, 8'h00, 8'hFF, 8'h03, 0, 1, 0, "load_ff");
    do_op(1'b1, 1'b1, 3'b000, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 1, 0, "inc_wrap");
    do_op(1'b1, 1'b1, 3'b001, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 1, 0, "dec_wrap");
    for (int i = 0; i < 3; i++)
      do_op(1'b1, 1'b0, 3'b000, 0, 8'h55, 8'h00, 8'hFF, 8'h00, 0, 1, 0, "hold");
    do_op(1'b1, 1'b1, 3'b010, 0, 8'h10, 8'h00, 8'h10, 8'hFF, 0, 1, 0, "load_10");
    do_op(1'b1, 1'b1, 3'b100, 0, 8'hFC, 8'h00, 8'h0C, 8'h10, 0, 1, 0, "rel_neg");
    do_op(1'b1, 1'b1, 3'b101, 0, 8'h40, 8'h00, 8'h0D, 8'h0C, 0, 1, 0, "cbr_nt");
    do_op(1'b1, 1'b1, 3'b101, 1, 8'h40, 8'h00, 8'h40, 8'h0D, 0, 1, 0, "cbr_t");
    do_op(1'b1, 1'b1, 3'b011, 0, 8'h00, 8'h33, 8'h33, 8'h40, 0, 1, 0, "alu");
    do_op(1'b1, 1'b1, 3'b100, 0, 8'h05, 8'h00, 8'h38, 8'h33, 0, 1, 0, "rel_pos");
    do_op(1'b1, 1'b1, 3'b010, 0, 8'h20, 8'h00, 8'h20, 8'h38, 0, 1, 0, "load_20");
    do_op(1'b1, 1'b1, 3'b110, 0, 8'h50, 8'h00, 8'h50, 8'h20, 0, 0, 0, "call_50");
    do_op(1'b1, 1'b1, 3'b110, 0, 8'h60, 8'h00, 8'h60, 8'h50, 0, 0, 0, "call_60");
    do_op(1'b1, 1'b1, 3'b111, 0, 8'h00, 8'h00, 8'h51, 8'h60, 0, 0, 0, "ret_51");
    do_op(1'b1, 1'b1, 3'b111, 0, 8'h00, 8'h00, 8'h21, 8'h51, 0, 1, 0, "ret_21");
    do_op(1'b1, 1'b1, 3'b110, 0, 8'h70, 8'h00, 8'h70, 8'h21, 0, 0, 0, "call_70");
    do_op(1'b1, 1'b1, 3'b110, 0, 8'h80, 8'h00, 8'h80, 8'h70, 0, 0, 0, "call_80");
    do_op(1'b1, 1'b1, 3'b110, 0, 8'h90, 8'h00, 8'h90, 8'h80, 0, 0, 0, "call_90");
    do_op(1'b1, 1'b1, 3'b110, 0, 8'hA0, 8'h00, 8'hA0, 8'h90, 1, 0, 0, "call_full");
    do_op(1'b1, 1'b1, 3'b110, 0, 8'hB0, 8'h00, 8'hA1, 8'hA0, 1, 0, 1, "call_ovf");
    do_op(1'b1, 1'b1, 3'b111, 0, 8'h00, 8'h00, 8'h91, 8'hA1, 0, 0, 1, "ret_91");
    do_op(1'b1, 1'b1, 3'b111, 0, 8'h00, 8'h00, 8'h81, 8'h91, 0, 0, 1, "ret_81");
    do_op(1'b1, 1'b1, 3'b111, 0, 8'h00, 8'h00, 8'h71, 8'h81, 0, 0, 1, "ret_71");
    do_op(1'b1, 1'b1, 3'b111, 0, 8'h00, 8'h00, 8'h22, 8'h71, 0, 1, 1, "ret_22");
    do_op(1'b0, 1'b1, 3'b000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, "reset2");
    do_op(1'b1, 1'b1, 3'b010, 0, 8'h07, 8'h00, 8'h07, 8'h00, 0, 1, 0, "load_07");
    do_op(1'b1, 1'b1, 3'b111, 0, 8'h00, 8'h00, 8'h08, 8'h07, 0, 1, 1, "ret_unf");
    do_op(1'b0, 1'b0, 3'b000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, "reset_noen");
    do_op(1'b1, 1'b1, 3'b010, 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 0, 1, 0, "load_ff2");
    do_op(1'b1, 1'b1, 3'b110, 0, 8'h10, 8'h00, 8'h10, 8'hFF, 0, 0, 0, "call_wrap");
    do_op(1'b1, 1'b1, 3'b111, 0, 8'h00, 8'h00, 8'h00, 8'h10, 0, 1, 0, "ret_wrap");
    do_op(1'b1, 1'b1, 3'b110, 0, 8'h30, 8'h00, 8'h30, 8'h00, 0, 0, 0, "call_30");
    do_op(1'b0, 1'b1, 3'b110, 0, 8'h40, 8'h00, 8'h00, 8'h00, 0, 1, 0, "reset_mid");
    do_op(1'b1, 1'b1, 3'b111, 0, 8'h00, 8'h00, 8'h01, 8'h00, 0, 1, 1, "ret_after");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain got %0d pending expectations, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
